bin_a_bcd: RTL
==============

// Module: bin_a_bcd
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3, "double dabble"), one bit per clock.
//  Sits directly downstream of the divider: takes the 32-bit cociente once finalizado pulses.
//  Produces packed BCD digits for the 7-segment display driver.
//  Start/done handshake matches the divider's comenzar/finalizado style.
// PARAMETERS
//  ANCHO_BIN  32  width of binary input
//  DIGITOS    10  BCD digits produced (10 covers 2^32-1 = 4294967295)
// PORTS
//  clock       in   1            system clock, all logic on posedge
//  rst         in   1            synchronous, active-high reset
//  comenzar    in   1            start request; rising edge detected internally
//  binario     in   ANCHO_BIN    unsigned value to convert (divider cociente)
//  bcd         out  4*DIGITOS    packed BCD, digit 0 (units) in [3:0]
//  apagar      out  DIGITOS      leading-zero blank mask (see CONFIGURATION)
//  ocupado     out  1            high while conversion in progress
//  finalizado  out  1            one-cycle pulse, bcd valid
//  desborde    out  1            value did not fit in DIGITOS digits
// BEHAVIOUR
//  Interface: one clock (clock); reset is synchronous and active-high (rst).
//  Reset: bcd=0, apagar=0, ocupado=0, finalizado=0, desborde=0, FSM->REPOSO, edge reg=0.
//  FSM: REPOSO -> CARGA -> DESPLAZA (ANCHO_BIN cycles) -> LISTO -> REPOSO.
//   REPOSO: wait for comenzar rising edge (comenzar & ~comenzar_q).
//   CARGA: latch binario into shift reg, clear BCD scratch, contador=ANCHO_BIN, ocupado=1.
//   DESPLAZA: each cycle add 3 to every scratch digit >=5, then shift {scratch,bin} left 1;
//    decrement contador; leave after last shift.
//   LISTO: copy scratch to bcd, set desborde, finalizado=1 for exactly this cycle, ocupado=0.
//  Latency: edge sampled at posedge N -> finalizado high during cycle N+ANCHO_BIN+2.
//  bcd/desborde hold until next LISTO; not modified during conversion.
//  comenzar edges while ocupado are ignored (not queued).
//  comenzar held high for several cycles -> exactly one conversion.
//  binario is only sampled in CARGA; later changes have no effect.
//  desborde=1 iff a 1 is shifted out of the top scratch digit; with defaults never set.
//  rst mid-conversion: aborts, outputs return to reset values next cycle, no finalizado.
//  rst and comenzar in same cycle: rst wins, edge register also cleared.
// CONFIGURATION
//  BCD_BLANK_EN defined: in LISTO, apagar[i]=1 for each digit i>0 that is 0 and has
//   only zero digits above it; digit 0 never blanked. Updated with bcd.
//  BCD_BLANK_EN undefined: apagar tied to 0; no blanking logic synthesized.
// STRUCTURE
//  Shared package calc_defs.vh: FSM state encodings (REPOSO/CARGA/DESPLAZA/LISTO),
//   ANCHO_BIN and DIGITOS default constants, shared with divider and display driver.
//  Sub-module bcd_ajuste_digito: combinational 4-bit "if >=5 add 3", instantiated DIGITOS
//   times via generate.
// TESTING
//  binario=1000/25 result 32'd40, comenzar 2 cycles -> one finalizado, bcd=40'h0000000040,
//   latency ANCHO_BIN+2 cycles from edge.
//  binario=0 -> bcd=0, desborde=0; with BCD_BLANK_EN apagar=10'h3FE, else 0.
//  binario=32'hFFFFFFFF -> bcd=40'h4294967295, desborde=0, apagar=0.
//  Second comenzar edge mid-conversion with different binario -> ignored, first result only.
//  rst asserted at shift 10 -> ocupado=0 next cycle, no finalizado, bcd=0; fresh start works.
//  Back-to-back 123 then 99999 -> bcd=...0123 then ...99999, each with single pulse.

Source files
------------

// File: rtl/bin_a_bcd_pkg.sv
// ============================================================================
//  Module      : bin_a_bcd_pkg
//  Description : Shared constants for the calculator datapath. Holds the FSM
//                state encodings and the default widths, and is used by the
//                divider, the BCD converter and the display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin_a_bcd_pkg;

  localparam int ANCHO_BIN_DEF = 32;
  localparam int DIGITOS_DEF   = 10;

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] CARGA    = 2'd1;
  localparam logic [1:0] DESPLAZA = 2'd2;
  localparam logic [1:0] LISTO    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/bin_a_bcd_ajuste_digito.sv
// ============================================================================
//  Module      : bin_a_bcd_ajuste_digito
//  Description : Combinational double-dabble correction for one BCD digit.
//                A digit of 5 or more gets 3 added to it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_a_bcd_ajuste_digito (
  input  logic [3:0] digito_in,
  output logic [3:0] digito_out
);

  assign digito_out = (digito_in >= 4'd5) ? digito_in + 4'd3 : digito_in;

endmodule

`default_nettype wire

// File: rtl/bin_a_bcd.sv
// ============================================================================
//  Module      : bin_a_bcd
//  Description : Sequential binary-to-BCD converter, shift-add-3, one bit per
//                clock. Optional leading-zero blanking when BCD_BLANK_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_a_bcd
  import bin_a_bcd_pkg::*;
#(
  parameter int ANCHO_BIN = ANCHO_BIN_DEF,
  parameter int DIGITOS   = DIGITOS_DEF
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   comenzar,
  input  logic [ANCHO_BIN-1:0]   binario,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic [DIGITOS-1:0]     apagar,
  output logic                   ocupado,
  output logic                   finalizado,
  output logic                   desborde
);

  localparam int CW = $clog2(ANCHO_BIN + 1);

  logic [1:0]             estado;
  logic                   comenzar_q;
  logic [ANCHO_BIN-1:0]   bin_sr;
  logic [4*DIGITOS-1:0]   scratch;
  logic [4*DIGITOS-1:0]   scratch_adj;
  logic [CW-1:0]          contador;
  logic                   desborde_acc;

  generate
    for (genvar d = 0; d < DIGITOS; d++) begin : g_ajuste
      bin_a_bcd_ajuste_digito u_ajuste (
        .digito_in  (scratch[4*d +: 4]),
        .digito_out (scratch_adj[4*d +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (rst) begin
      estado       <= REPOSO;
      comenzar_q   <= 1'b0;
      bin_sr       <= '0;
      scratch      <= '0;
      contador     <= '0;
      desborde_acc <= 1'b0;
      bcd          <= '0;
      ocupado      <= 1'b0;
      finalizado   <= 1'b0;
      desborde     <= 1'b0;
    end else begin
      comenzar_q <= comenzar;
      finalizado <= 1'b0;
      case (estado)
        REPOSO: begin
          if (comenzar && !comenzar_q) estado <= CARGA;
        end
        CARGA: begin
          bin_sr       <= binario;
          scratch      <= '0;
          contador     <= CW'(ANCHO_BIN);
          desborde_acc <= 1'b0;
          ocupado      <= 1'b1;
          estado       <= DESPLAZA;
        end
        DESPLAZA: begin
          // Whatever leaves the top digit is lost, so remember it as overflow.
          scratch      <= {scratch_adj[4*DIGITOS-2:0], bin_sr[ANCHO_BIN-1]};
          bin_sr       <= {bin_sr[ANCHO_BIN-2:0], 1'b0};
          desborde_acc <= desborde_acc | scratch_adj[4*DIGITOS-1];
          contador     <= contador - CW'(1);
          if (contador == CW'(1)) estado <= LISTO;
        end
        LISTO: begin
          bcd        <= scratch;
          desborde   <= desborde_acc;
          finalizado <= 1'b1;
          ocupado    <= 1'b0;
          estado     <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITOS-1:0] mascara;
  logic               solo_ceros;

  // Walk from the most significant digit down; units digit always shown.
  always_comb begin
    mascara    = '0;
    solo_ceros = 1'b1;
    for (int i = DIGITOS - 1; i > 0; i--) begin
      solo_ceros = solo_ceros & (scratch[4*i +: 4] == 4'd0);
      mascara[i] = solo_ceros;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      apagar <= '0;
    end else if (estado == LISTO) begin
      apagar <= mascara;
    end
  end
`else
  assign apagar = '0;
`endif

endmodule

`default_nettype wire
